// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared data-memory size codes, LSU fault codes and LSU state type.
// Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    // Size codes shared with the data memory read_size input
    localparam logic [2:0] MEM_BYTE_SIGNED       = 3'b000;
    localparam logic [2:0] MEM_HALFWORD_SIGNED   = 3'b001;
    localparam logic [2:0] MEM_WORD_SIGNED       = 3'b010;
    localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
    localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

    localparam logic [1:0] FAULT_OK         = 2'b00;
    localparam logic [1:0] FAULT_MISALIGNED = 2'b01;
    localparam logic [1:0] FAULT_RANGE      = 2'b10;
    localparam logic [1:0] FAULT_SIZE       = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_access_check.sv
`default_nettype none
// ============================================================================
// Module   : lsu_access_check
// Purpose  : Combinational size / alignment / range check for one LSU request.
// Revision : 1.0  initial release
// ============================================================================
module lsu_access_check
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MEM_BYTES = 1024
) (
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    output logic [1:0]  fault,
    output logic [2:0]  nbytes
);

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic [32:0] w_end;

    always_comb begin
        w_illegal = 1'b0;
        nbytes    = 3'd0;
        case (size)
            MEM_BYTE_SIGNED, MEM_BYTE_UNSIGNED:         nbytes = 3'd1;
            MEM_HALFWORD_SIGNED, MEM_HALFWORD_UNSIGNED: nbytes = 3'd2;
            MEM_WORD_SIGNED:                            nbytes = 3'd4;
            default:                                    w_illegal = 1'b1;
        endcase

        w_misaligned = ((nbytes == 3'd2) && addr[0]) ||
                       ((nbytes == 3'd4) && (addr[1:0] != 2'b00));

        // 33-bit sum so an access ending exactly at the top of the space cannot wrap
        w_end          = {1'b0, addr} + {30'd0, nbytes};
        w_out_of_range = ((addr >> ADDR_W) != 32'd0) || (w_end > 33'(MEM_BYTES));

        if (w_illegal)
            fault = FAULT_SIZE;
        else if (w_misaligned)
            fault = FAULT_MISALIGNED;
        else if (w_out_of_range)
            fault = FAULT_RANGE;
        else
            fault = FAULT_OK;
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage initiator: one checked load/store at a time, one held response.
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic              mem_we,
    output logic [2:0]        mem_size,
    input  logic [31:0]       mem_rd_data
);

    lsu_state_t        r_state;
    lsu_state_t        w_next_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wr_data;
    logic [2:0]        r_mem_size;
    logic [31:0]       r_resp_rdata;
    logic [1:0]        r_resp_fault;
    logic [1:0]        w_fault;
    logic [2:0]        w_unused_nbytes;
    logic              w_accept;

    lsu_access_check #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .size   (req_size),
        .addr   (req_addr),
        .fault  (w_fault),
        .nbytes (w_unused_nbytes)
    );

    assign w_accept = req_valid && (r_state == LSU_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= LSU_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (req_valid)
                    w_next_state = (w_fault != FAULT_OK) ? LSU_RESP : LSU_ACCESS;
            end
            LSU_ACCESS: w_next_state = LSU_RESP;
            LSU_RESP: begin
                if (resp_ready)
                    w_next_state = LSU_IDLE;
            end
            default: w_next_state = LSU_IDLE;
        endcase
    end

    // Decoded straight from the async-reset state so mem_we drops the instant rst rises
    always_comb begin
        req_ready  = (r_state == LSU_IDLE);
        resp_valid = (r_state == LSU_RESP);
        mem_we     = (r_state == LSU_ACCESS) && r_we;
    end

    // Memory-side registers load only for legal requests, so a faulting
    // request leaves the memory bus exactly as the last real access left it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we          <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_mem_size    <= MEM_WORD_SIGNED;
            r_resp_rdata  <= '0;
            r_resp_fault  <= FAULT_OK;
        end else begin
            if (w_accept) begin
                r_we <= req_we;
                if (w_fault == FAULT_OK) begin
                    r_mem_addr    <= req_addr[ADDR_W-1:0];
                    r_mem_wr_data <= req_wdata;
                    r_mem_size    <= req_size;
                end else begin
                    r_resp_rdata <= '0;
                    r_resp_fault <= w_fault;
                end
            end
            if (r_state == LSU_ACCESS) begin
                r_resp_rdata <= r_we ? 32'd0 : mem_rd_data;
                r_resp_fault <= FAULT_OK;
            end
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign mem_size    = r_mem_size;
    assign resp_rdata  = r_resp_rdata;
    assign resp_fault  = r_resp_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench: directed table, hand sequences, random vs. model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_load_store_unit;
    import mem_pkg::*;

    localparam int ADDR_W    = 12;
    localparam int MEM_BYTES = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_size;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_fault;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_we;
    logic [2:0]        mem_size;
    logic [31:0]       mem_rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int we_pulses = 0;

    logic [7:0] env_mem [0:4095];
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_rd_data(mem_rd_data)
    );

    // Big-endian byte memory with size-coded extension, as the real data memory behaves
    function automatic logic [31:0] env_read(input logic [ADDR_W-1:0] a, input logic [2:0] s);
        logic [ADDR_W-1:0] a1, a2, a3;
        a1 = a + 12'd1; a2 = a + 12'd2; a3 = a + 12'd3;
        case (s)
            MEM_BYTE_SIGNED:       return {{24{env_mem[a][7]}}, env_mem[a]};
            MEM_BYTE_UNSIGNED:     return {24'd0, env_mem[a]};
            MEM_HALFWORD_SIGNED:   return {{16{env_mem[a][7]}}, env_mem[a], env_mem[a1]};
            MEM_HALFWORD_UNSIGNED: return {16'd0, env_mem[a], env_mem[a1]};
            default:               return {env_mem[a], env_mem[a1], env_mem[a2], env_mem[a3]};
        endcase
    endfunction

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_pulses++;
            case (mem_size)
                MEM_BYTE_SIGNED, MEM_BYTE_UNSIGNED:
                    env_mem[mem_addr] = mem_wr_data[7:0];
                MEM_HALFWORD_SIGNED, MEM_HALFWORD_UNSIGNED: begin
                    env_mem[mem_addr]         = mem_wr_data[15:8];
                    env_mem[mem_addr + 12'd1] = mem_wr_data[7:0];
                end
                default: begin
                    env_mem[mem_addr]         = mem_wr_data[31:24];
                    env_mem[mem_addr + 12'd1] = mem_wr_data[23:16];
                    env_mem[mem_addr + 12'd2] = mem_wr_data[15:8];
                    env_mem[mem_addr + 12'd3] = mem_wr_data[7:0];
                end
            endcase
        end
        mem_rd_data = env_read(mem_addr, mem_size);
    end

    // Reference model: what the core should see for a request, from the access rules alone
    function automatic void ref_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                       input logic [31:0] wdata, output logic [1:0] fault,
                                       output logic [31:0] rdata);
        int     n;
        bit     sgn;
        longint val;
        longint last;
        n = 0; sgn = 1'b0; rdata = 32'd0;
        case (size)
            3'd0: begin n = 1; sgn = 1'b1; end
            3'd4: n = 1;
            3'd1: begin n = 2; sgn = 1'b1; end
            3'd5: n = 2;
            3'd2: begin n = 4; sgn = 1'b1; end
            default: n = 0;
        endcase
        last = longint'({32'd0, addr}) + longint'(n);
        if (n == 0)
            fault = 2'b11;
        else if ((addr % n) != 0)
            fault = 2'b01;
        else if (last > longint'(MEM_BYTES))
            fault = 2'b10;
        else begin
            fault = 2'b00;
            if (we) begin
                for (int i = 0; i < n; i++)
                    ref_mem[int'(addr) + i] = 8'(wdata >> (8 * (n - 1 - i)));
            end else begin
                val = 0;
                for (int i = 0; i < n; i++)
                    val = val * 256 + longint'(ref_mem[int'(addr) + i]);
                if (sgn && val >= (64'sd1 <<< (8 * n - 1)))
                    val = val - (64'sd1 <<< (8 * n));
                rdata = 32'(val);
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic [1:0] fault,
                          output int lat, output int wes);
        int w0;
        bit stable;
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
        w0 = we_pulses;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_size  = 3'($urandom_range(0, 7));
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rdata  = resp_rdata;
        fault  = resp_fault;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_fault !== fault || req_ready !== 1'b0)
                stable = 1'b0;
        end
        req_valid = 1'b0;
        check("resp_hold_stable", {31'd0, stable}, 32'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
        check("req_ready_back", {31'd0, req_ready}, 32'd1);
        wes = we_pulses - w0;
    endtask

    task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold,
                           input logic [1:0] exp_fault, input logic [31:0] exp_rdata);
        logic [31:0] rdata;
        logic [1:0]  fault;
        int          lat, wes;
        do_req(we, size, addr, wdata, hold, rdata, fault, lat, wes);
        check("resp_fault", {30'd0, fault}, {30'd0, exp_fault});
        check("resp_rdata", rdata, exp_rdata);
        check("resp_latency", lat, (exp_fault != 2'b00) ? 32'd1 : 32'd2);
        check("mem_we_pulses", wes, (exp_fault == 2'b00 && we) ? 32'd1 : 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  fault;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [1:0]  f_dummy;
        logic [31:0] r_dummy;
        logic [1:0]  ef;
        logic [31:0] er;
        logic        rwe;
        logic [2:0]  rsz;
        logic [31:0] rad;
        logic [31:0] rwd;

        for (int i = 0; i < 4096; i++) env_mem[i] = 8'h00;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;

        vecs[0]  = '{1'b1, MEM_WORD_SIGNED,       32'h010,       32'hDEADBEEF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, MEM_BYTE_SIGNED,       32'h010,       32'h0,        2'b00, 32'hFFFFFFDE};
        vecs[2]  = '{1'b0, MEM_BYTE_UNSIGNED,     32'h011,       32'h0,        2'b00, 32'h000000AD};
        vecs[3]  = '{1'b0, MEM_HALFWORD_SIGNED,   32'h012,       32'h0,        2'b00, 32'hFFFFBEEF};
        vecs[4]  = '{1'b1, MEM_WORD_SIGNED,       32'h002,       32'h11223344, 2'b01, 32'h0};
        vecs[5]  = '{1'b0, MEM_WORD_SIGNED,       32'h400,       32'h0,        2'b10, 32'h0};
        vecs[6]  = '{1'b0, 3'b011,                32'h000,       32'h0,        2'b11, 32'h0};
        vecs[7]  = '{1'b0, MEM_HALFWORD_SIGNED,   32'h3FF,       32'h0,        2'b01, 32'h0};
        vecs[8]  = '{1'b0, MEM_HALFWORD_UNSIGNED, 32'h010,       32'h0,        2'b00, 32'h0000DEAD};
        vecs[9]  = '{1'b1, MEM_BYTE_UNSIGNED,     32'h3FF,       32'h12345678, 2'b00, 32'h0};
        vecs[10] = '{1'b0, MEM_BYTE_UNSIGNED,     32'h3FF,       32'h0,        2'b00, 32'h00000078};
        vecs[11] = '{1'b1, MEM_HALFWORD_SIGNED,   32'h3FE,       32'h000080AB, 2'b00, 32'h0};
        vecs[12] = '{1'b0, MEM_HALFWORD_SIGNED,   32'h3FE,       32'h0,        2'b00, 32'hFFFF80AB};
        vecs[13] = '{1'b0, MEM_WORD_SIGNED,       32'h3FC,       32'h0,        2'b00, 32'h000080AB};
        vecs[14] = '{1'b0, 3'b111,                32'h001,       32'h0,        2'b11, 32'h0};
        vecs[15] = '{1'b0, MEM_WORD_SIGNED,       32'h1000_0000, 32'h0,        2'b10, 32'h0};
        vecs[16] = '{1'b0, MEM_BYTE_UNSIGNED,     32'h400,       32'h0,        2'b10, 32'h0};
        vecs[17] = '{1'b0, MEM_WORD_SIGNED,       32'h010,       32'h0,        2'b00, 32'hDEADBEEF};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 3'd0; req_addr = 32'd0;
        req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",   {31'd0, req_ready},  32'd1);
        check("rst_resp_valid",  {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata",  resp_rdata,          32'd0);
        check("rst_resp_fault",  {30'd0, resp_fault}, 32'd0);
        check("rst_mem_we",      {31'd0, mem_we},     32'd0);
        check("rst_mem_addr",    {20'd0, mem_addr},   32'd0);
        check("rst_mem_wr_data", mem_wr_data,         32'd0);
        check("rst_mem_size",    {29'd0, mem_size},   32'd2);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            ref_access(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, f_dummy, r_dummy);
            run_txn(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, 0,
                    vecs[i].fault, vecs[i].rdata);
        end

        // Backpressure: response held for 5 cycles while extra req_valid is asserted
        run_txn(1'b0, MEM_WORD_SIGNED, 32'h010, 32'h0, 5, 2'b00, 32'hDEADBEEF);

        // Reset while a response is pending
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = MEM_WORD_SIGNED; req_addr = 32'h010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4 && resp_valid !== 1'b1; i++) @(negedge clk);
        check("pre_reset_resp_valid", {31'd0, resp_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("async_rst_req_ready",  {31'd0, req_ready},  32'd1);
        check("async_rst_mem_we",     {31'd0, mem_we},     32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(1'b0, MEM_WORD_SIGNED, 32'h010, 32'h0, 0, 2'b00, 32'hDEADBEEF);

        for (int t = 0; t < 200; t++) begin
            rwe = 1'($urandom_range(0, 1));
            rsz = 3'($urandom_range(0, 7));
            rwd = $urandom;
            case ($urandom_range(0, 3))
                0:       rad = $urandom;
                1:       rad = 32'($urandom_range(MEM_BYTES - 8, MEM_BYTES + 3));
                default: rad = 32'($urandom_range(0, 63));
            endcase
            ref_access(rwe, rsz, rad, rwd, ef, er);
            run_txn(rwe, rsz, rad, rwd, $urandom_range(0, 3), ef, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Pipeline-side initiator for the byte-addressed data memory. It is the MEM-stage requester that drives mem_addr / wr_data / we / size and captures the load data.
- Accepts one load or store at a time from the core over a valid/ready handshake. Rejects illegal, misaligned and out-of-range accesses with a fault code, without touching memory.
- Returns one registered response per request, held until the core accepts it.

Parameters:
- ADDR_W, 12, width of the memory address port.
- MEM_BYTES, 1024, number of implemented bytes; the legal address range is 0 to MEM_BYTES-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  access size code (package constants).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  load result, already extended; 0 for stores and faults.
- resp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal size.
- mem_addr  out  ADDR_W  to data memory.
- mem_wr_data  out  32  to data memory.
- mem_we  out  1  memory write enable.
- mem_size  out  3  to the memory read_size input.
- mem_rd_data  in  32  combinational read data from memory.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - state IDLE; req_ready 1; resp_valid 0; resp_rdata 0; resp_fault 00.
  - mem_we 0; mem_addr 0; mem_wr_data 0; mem_size 3'b010.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we/size/addr/wdata into registers and run the checks below in the same cycle.
  - Fault found: go to RESP with the fault code and rdata 0.
  - Otherwise: go to ACCESS.
- Check priority, highest first:
  - illegal size (3'b011, 3'b110, 3'b111) -> 11.
  - misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) -> 01.
  - out of range (addr[31:ADDR_W]!=0, or addr+nbytes > MEM_BYTES) -> 10.
- ACCESS, exactly one cycle:
  - mem_addr=addr[ADDR_W-1:0], mem_size=size, mem_wr_data=wdata.
  - mem_we=1 only for stores; mem_we is 1 in no other state.
  - Loads: mem_rd_data is registered into resp_rdata at the end of the cycle.
  - Next state: RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_fault held stable while resp_ready=0.
  - On resp_ready, go to IDLE; resp_valid drops the next cycle.
- req_ready is 0 in ACCESS and RESP. Requests are not queued.
- Latency: an accepted legal request gives resp_valid 2 cycles after the accept edge. A faulting request gives it 1 cycle after. Minimum interval between requests is 3 cycles.
- Byte order is big-endian; the lowest address holds the most significant byte. Sign/zero extension is done by memory per size code. The unit passes mem_rd_data through unmodified.
- Reset mid-operation: the unit returns to IDLE immediately. mem_we deasserts asynchronously. A pending response is discarded, and a store in ACCESS may or may not have committed.
- mem_* outputs hold their last values outside ACCESS, with mem_we=0.

Decomposition:
- Shared package mem_pkg holds the size codes, reused by the data memory:
  - MEM_BYTE_SIGNED=3'b000
  - MEM_HALFWORD_SIGNED=3'b001
  - MEM_WORD_SIGNED=3'b010
  - MEM_BYTE_UNSIGNED=3'b100
  - MEM_HALFWORD_UNSIGNED=3'b101
- The package also holds the fault-code constants and the lsu_state_t enum.
- One combinational sub-module, lsu_access_check, contains the size, alignment and range checks. It outputs the fault code and nbytes.

Test Plan:
- Store MEM_WORD_SIGNED 0xDEADBEEF to 0x010:
  - mem_we high exactly one cycle.
  - resp_fault 00, resp_rdata 0.
- Loads after that store:
  - MEM_BYTE_SIGNED at 0x010 -> 0xFFFFFFDE.
  - MEM_BYTE_UNSIGNED at 0x011 -> 0x000000AD.
  - MEM_HALFWORD_SIGNED at 0x012 -> 0xFFFFBEEF.
- Fault cases, each with mem_we never asserted and resp_valid one cycle after accept:
  - word store to 0x002 -> fault 01.
  - word load at 0x400 -> fault 10.
  - size 3'b011 at 0x000 -> fault 11.
  - halfword at 0x3FF -> fault 01 (priority over out-of-range).
- Backpressure: load from 0x010 with resp_ready=0 for 5 cycles:
  - resp_valid stays 1 and resp_rdata is stable at the load value.
  - req_ready stays 0 and a new req_valid is ignored.
  - After resp_ready, req_ready returns 1 one cycle later.
- Reset asserted during RESP:
  - resp_valid=0 and req_ready=1 immediately.
  - A subsequent word load of 0x010 completes normally.
